irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, meaning the number of interrupt source lines (1..31).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-004 SHALL have port src_irq, input, N_SRC bits, meaning peripheral interrupt lines (systick irq on bit 0), synchronous to clk.
REQ-005 SHALL have port select, input, 1 bit, meaning a bus access is addressed to this block.
REQ-006 SHALL have port wstrb, input, 4 bits, meaning 0 for a read and non-zero for a full-word write.
REQ-007 SHALL have port addr, input, 5 bits, meaning the byte offset of the 32-byte register space.
REQ-008 SHALL have port data_i, input, 32 bits, meaning write data.
REQ-009 SHALL have port ready, output, 1 bit, meaning the access has completed.
REQ-010 SHALL have port data_o, output, 32 bits, meaning read data, valid while ready=1.
REQ-011 SHALL have port cpu_irq, output, N_SRC bits, meaning per-source interrupt requests to the CPU.
REQ-012 SHALL have port irq_any, output, 1 bit, meaning OR of cpu_irq.

Function
REQ-013 SHALL provide the following register map, with unused bits reading 0:
- 0x00 ENABLE: RW.
- 0x04 PENDING: R; writing 1 to a bit clears it (W1C).
- 0x08 MODE: RW; bit=1 selects rising-edge, bit=0 selects level.
- 0x0C CLAIM: R.
- 0x10 ACTIVE: R; returns PENDING & ENABLE.
REQ-014 SHALL return 0 for reads of offsets 0x14-0x1C and ignore writes to them and to read-only registers.
REQ-015 SHALL perform one access per transaction: the access executes in the cycle where select=1 and ready=0; ready=1 the next cycle for exactly one cycle; data_o is registered in that same step.
REQ-016 SHALL hold ready=0 for one cycle after a completed access even if select stays high; a held select therefore yields one access every 2 cycles.
REQ-017 SHALL keep a registered copy src_q of src_irq for edge detection.
REQ-018 SHALL set PENDING[i] in edge mode when src_irq[i]=1 and src_q[i]=0, and in level mode whenever src_irq[i]=1.
REQ-019 SHALL give the set priority over clear when a set condition and a W1C or claim-clear target the same bit in the same cycle.
REQ-020 SHALL set PENDING regardless of ENABLE; enabling a bit that is already pending SHALL raise cpu_irq.
REQ-021 SHALL compute the CLAIM read value as follows:
- If ACTIVE≠0: bit31=1 and bits[4:0]=lowest index i with ACTIVE[i]=1.
- Otherwise the value is 0.
REQ-022 SHALL clear the claimed PENDING bit as a side effect of a CLAIM read, in the same cycle the read executes (subject to REQ-019).
REQ-023 SHALL register cpu_irq = PENDING & ENABLE, giving 1-cycle latency from a PENDING/ENABLE change to cpu_irq; irq_any SHALL be registered alongside cpu_irq.
REQ-024 SHALL leave PENDING unchanged on MODE writes.
REQ-025 SHALL keep a 1-cycle systick irq pulse pending until cleared, in edge mode.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, clear ENABLE, PENDING, MODE, src_q, ready, data_o, cpu_irq and irq_any to 0.
REQ-027 SHALL let reset override any in-progress access and any set event in the same cycle.
REQ-028 SHALL NOT detect an edge in the first cycle after reset if a source is already high when reset releases (src_q loads the source that cycle); level-mode sources SHALL set PENDING immediately.

Verification
REQ-029 Edge pulse: MODE=0x1, ENABLE=0x1, 1-cycle pulse on src_irq[0] -> PENDING=0x1 next cycle; cpu_irq[0]=1 one cycle later; stays set after the pulse ends.
REQ-030 Claim: PENDING bits 2 and 5 set, both enabled -> CLAIM read returns 0x80000002; a second read returns 0x80000005; a third returns 0x00000000; cpu_irq=0 afterwards.
REQ-031 W1C vs level: MODE=0, src_irq[3] held high, write 0x08 to PENDING -> PENDING[3] stays 1; drop source, write again -> PENDING[3]=0.
REQ-032 Simultaneous set/clear: rising edge on src 1 in the same cycle as a W1C of bit 1 -> PENDING[1]=1.
REQ-033 Handshake: select held high for 6 cycles on a CLAIM read -> exactly 3 ready pulses, each one cycle wide, each clearing one claim.
REQ-034 Reset mid-operation: reset asserted for one cycle with pending and enabled sources and select=1 -> all registers and outputs 0 the next cycle; no ready pulse.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl -- memory-mapped interrupt controller.
//
// Collects N_SRC peripheral interrupt lines into a PENDING register (each
// line individually level or rising-edge sensitive), masks them with
// ENABLE, and presents per-source requests plus a combined request to the
// CPU. A CLAIM register returns the lowest-numbered active source and
// clears it as a side effect of the read.
//
// Register map (byte offsets, unused bits read 0):
//   0x00 ENABLE  RW
//   0x04 PENDING R, write-1-to-clear
//   0x08 MODE    RW, 1 = rising edge, 0 = level
//   0x0C CLAIM   R, {valid, 26'b0, id[4:0]}
//   0x10 ACTIVE  R, PENDING & ENABLE
//   0x14..0x1C   read 0, writes ignored
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   src_irq  peripheral interrupt lines (bit 0 = systick)
//   select   bus access addressed to this block
//   wstrb    0 = read, non-zero = full-word write
//   addr     byte offset into the 32-byte register space
//   data_i   write data
//   ready    one-cycle completion pulse for an access
//   data_o   read data, valid while ready = 1
//   cpu_irq  registered PENDING & ENABLE
//   irq_any  registered OR of cpu_irq

module irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             select,
    input  logic [3:0]       wstrb,
    input  logic [4:0]       addr,
    input  logic [31:0]      data_i,
    output logic             ready,
    output logic [31:0]      data_o,
    output logic [N_SRC-1:0] cpu_irq,
    output logic             irq_any
);

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_MODE    = 3'd2;
    localparam logic [2:0] REG_CLAIM   = 3'd3;
    localparam logic [2:0] REG_ACTIVE  = 3'd4;

    function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
        return {{(32 - N_SRC){1'b0}}, v};
    endfunction

    logic [N_SRC-1:0] enable_q,  enable_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mode_q,    mode_d;
    logic [N_SRC-1:0] src_q;
    logic             ready_q,   ready_d;
    logic [31:0]      data_q,    data_d;
    logic [N_SRC-1:0] cpu_irq_q, cpu_irq_d;
    logic             irq_any_q, irq_any_d;

    logic             access, wr_acc, rd_acc;
    logic [N_SRC-1:0] active, claim_mask, set_mask, clr_mask;
    logic [4:0]       claim_id;
    logic [31:0]      rdata;

    // Byte-lane bits of the address and upper write-data bits carry no
    // information in this register file.
    logic             unused_bits;
    assign unused_bits = ^{addr[1:0], data_i};

    always_comb begin
        // An access executes only while ready is low, so a held select
        // produces one access every other cycle.
        access = select && !ready_q;
        wr_acc = access && (wstrb != 4'd0);
        rd_acc = access && (wstrb == 4'd0);

        active = pending_q & enable_q;

        // Lowest set bit of active, both as an index and as a one-hot mask.
        claim_id = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) claim_id = 5'(i);
        end
        claim_mask = active & (~active + N_SRC'(1));

        rdata = 32'd0;
        case (addr[4:2])
            REG_ENABLE:  rdata = zext(enable_q);
            REG_PENDING: rdata = zext(pending_q);
            REG_MODE:    rdata = zext(mode_q);
            REG_CLAIM:   rdata = (active != '0) ? {1'b1, 26'd0, claim_id} : 32'd0;
            REG_ACTIVE:  rdata = zext(active);
            default:     rdata = 32'd0;
        endcase

        // Edge-mode bits fire on a 0->1 transition, level-mode bits whenever high.
        set_mask = (mode_q & src_irq & ~src_q) | (~mode_q & src_irq);

        clr_mask = '0;
        if (wr_acc && addr[4:2] == REG_PENDING) clr_mask = data_i[N_SRC-1:0];
        if (rd_acc && addr[4:2] == REG_CLAIM)   clr_mask = clr_mask | claim_mask;

        // Set wins over a same-cycle clear.
        pending_d = (pending_q & ~clr_mask) | set_mask;

        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_acc && addr[4:2] == REG_ENABLE) enable_d = data_i[N_SRC-1:0];
        if (wr_acc && addr[4:2] == REG_MODE)   mode_d   = data_i[N_SRC-1:0];

        ready_d   = access;
        data_d    = rd_acc ? rdata : 32'd0;
        cpu_irq_d = active;
        irq_any_d = |active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            pending_q <= '0;
            mode_q    <= '0;
            src_q     <= '0;
            ready_q   <= 1'b0;
            data_q    <= 32'd0;
            cpu_irq_q <= '0;
            irq_any_q <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            src_q     <= src_irq;
            ready_q   <= ready_d;
            data_q    <= data_d;
            cpu_irq_q <= cpu_irq_d;
            irq_any_q <= irq_any_d;
        end
    end

    assign ready   = ready_q;
    assign data_o  = data_q;
    assign cpu_irq = cpu_irq_q;
    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl -- directed bench for irq_ctrl (N_SRC = 8): a vector table of
// register accesses followed by hand-written multi-cycle sequences.

module tb_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  src_irq;
    logic        select;
    logic [3:0]  wstrb;
    logic [4:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;
    logic [7:0]  cpu_irq;
    logic        irq_any;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl #(.N_SRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .select  (select),
        .wstrb   (wstrb),
        .addr    (addr),
        .data_i  (data_i),
        .ready   (ready),
        .data_o  (data_o),
        .cpu_irq (cpu_irq),
        .irq_any (irq_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          wr;
        logic [4:0]  a;
        logic [31:0] wdata;
        logic [7:0]  src;
        logic [31:0] exp_rd;
        logic [7:0]  exp_irq;
    } vec_t;

    vec_t vecs[28];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        select  = 1'b0;
        wstrb   = 4'd0;
        addr    = 5'd0;
        data_i  = 32'd0;
        src_irq = 8'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic access(input bit wr, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rdv);
        select = 1'b1;
        wstrb  = wr ? 4'hF : 4'h0;
        addr   = a;
        data_i = d;
        tick();
        check("ready pulse", {31'd0, ready}, 32'd1);
        rdv    = data_o;
        select = 1'b0;
        wstrb  = 4'h0;
        tick();
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        access(1'b1, a, d, dummy);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        access(1'b0, a, 32'd0, v);
        check(name, v, exp);
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] got[3];
        int          pulses;

        // wr, addr, wdata, src (applied one cycle before the access), read value, cpu_irq after
        vecs[0]  = '{0, 5'h00, 32'h0,        8'h00, 32'h0,        8'h00};
        vecs[1]  = '{1, 5'h00, 32'h000001A5, 8'h00, 32'h0,        8'h00};
        vecs[2]  = '{0, 5'h00, 32'h0,        8'h00, 32'h000000A5, 8'h00};
        vecs[3]  = '{1, 5'h08, 32'h0000000F, 8'h00, 32'h0,        8'h00};
        vecs[4]  = '{0, 5'h08, 32'h0,        8'h00, 32'h0000000F, 8'h00};
        vecs[5]  = '{0, 5'h04, 32'h0,        8'h30, 32'h00000030, 8'h20};
        vecs[6]  = '{0, 5'h10, 32'h0,        8'h00, 32'h00000020, 8'h20};
        vecs[7]  = '{0, 5'h0C, 32'h0,        8'h00, 32'h80000005, 8'h00};
        vecs[8]  = '{0, 5'h0C, 32'h0,        8'h00, 32'h00000000, 8'h00};
        vecs[9]  = '{0, 5'h04, 32'h0,        8'h00, 32'h00000010, 8'h00};
        vecs[10] = '{1, 5'h04, 32'h00000010, 8'h00, 32'h0,        8'h00};
        vecs[11] = '{0, 5'h04, 32'h0,        8'h00, 32'h00000000, 8'h00};
        vecs[12] = '{0, 5'h14, 32'h0,        8'h00, 32'h00000000, 8'h00};
        vecs[13] = '{1, 5'h18, 32'hFFFFFFFF, 8'h00, 32'h0,        8'h00};
        vecs[14] = '{1, 5'h0C, 32'hFFFFFFFF, 8'h00, 32'h0,        8'h00};
        vecs[15] = '{1, 5'h10, 32'hFFFFFFFF, 8'h00, 32'h0,        8'h00};
        vecs[16] = '{0, 5'h00, 32'h0,        8'h00, 32'h000000A5, 8'h00};
        vecs[17] = '{0, 5'h08, 32'h0,        8'h00, 32'h0000000F, 8'h00};
        vecs[18] = '{0, 5'h1C, 32'h0,        8'h00, 32'h00000000, 8'h00};
        vecs[19] = '{0, 5'h04, 32'h0,        8'h01, 32'h00000001, 8'h01};
        vecs[20] = '{1, 5'h04, 32'h00000001, 8'h01, 32'h0,        8'h00};
        vecs[21] = '{0, 5'h04, 32'h0,        8'h01, 32'h00000000, 8'h00};
        vecs[22] = '{0, 5'h04, 32'h0,        8'h40, 32'h00000040, 8'h00};
        vecs[23] = '{1, 5'h08, 32'h0000004F, 8'h00, 32'h0,        8'h00};
        vecs[24] = '{0, 5'h04, 32'h0,        8'h00, 32'h00000040, 8'h00};
        vecs[25] = '{1, 5'h00, 32'h000000FF, 8'h00, 32'h0,        8'h40};
        vecs[26] = '{0, 5'h10, 32'h0,        8'h00, 32'h00000040, 8'h40};
        vecs[27] = '{1, 5'h04, 32'h00000040, 8'h00, 32'h0,        8'h00};

        do_reset();
        check("reset ready",   {31'd0, ready},   32'd0);
        check("reset data_o",  data_o,           32'd0);
        check("reset cpu_irq", {24'd0, cpu_irq}, 32'd0);
        check("reset irq_any", {31'd0, irq_any}, 32'd0);

        for (int i = 0; i < 28; i++) begin
            src_irq = vecs[i].src;
            tick();
            access(vecs[i].wr, vecs[i].a, vecs[i].wdata, rv);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rv, vecs[i].exp_rd);
            check($sformatf("vec%0d cpu_irq", i), {24'd0, cpu_irq}, {24'd0, vecs[i].exp_irq});
            check($sformatf("vec%0d irq_any", i), {31'd0, irq_any},
                  {31'd0, (vecs[i].exp_irq != 8'd0)});
        end

        // Edge pulse on systick: latency and stickiness.
        do_reset();
        wr_reg(5'h08, 32'h1);
        wr_reg(5'h00, 32'h1);
        src_irq = 8'h01;
        tick();
        src_irq = 8'h00;
        check("edge irq before latency", {24'd0, cpu_irq}, 32'd0);
        tick();
        check("edge cpu_irq", {24'd0, cpu_irq}, 32'h1);
        check("edge irq_any", {31'd0, irq_any}, 32'h1);
        tick();
        rd_check("edge pending sticky", 5'h04, 32'h1);

        // Claim sequence on bits 2 and 5.
        do_reset();
        wr_reg(5'h00, 32'h24);
        src_irq = 8'h24;
        tick();
        src_irq = 8'h00;
        tick();
        check("claim pre cpu_irq", {24'd0, cpu_irq}, 32'h24);
        rd_check("claim 1", 5'h0C, 32'h80000002);
        rd_check("claim 2", 5'h0C, 32'h80000005);
        rd_check("claim 3", 5'h0C, 32'h00000000);
        tick();
        check("claim post cpu_irq", {24'd0, cpu_irq}, 32'd0);

        // W1C against a held level source.
        do_reset();
        src_irq = 8'h08;
        tick();
        wr_reg(5'h04, 32'h08);
        rd_check("w1c level held", 5'h04, 32'h08);
        src_irq = 8'h00;
        tick();
        wr_reg(5'h04, 32'h08);
        rd_check("w1c level dropped", 5'h04, 32'h00);

        // Rising edge on src 1 coincident with W1C of bit 1.
        do_reset();
        wr_reg(5'h08, 32'h02);
        src_irq = 8'h02;
        select  = 1'b1;
        wstrb   = 4'hF;
        addr    = 5'h04;
        data_i  = 32'h02;
        tick();
        check("setclr ready", {31'd0, ready}, 32'd1);
        select = 1'b0;
        wstrb  = 4'h0;
        tick();
        rd_check("set beats clear", 5'h04, 32'h02);

        // Held select on CLAIM for six cycles.
        do_reset();
        wr_reg(5'h00, 32'h0E);
        src_irq = 8'h0E;
        tick();
        src_irq = 8'h00;
        tick();
        select = 1'b1;
        wstrb  = 4'h0;
        addr   = 5'h0C;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("held ready c%0d", k), {31'd0, ready}, {31'd0, (k % 2 == 0)});
            if (ready && pulses < 3) begin
                got[pulses] = data_o;
                pulses++;
            end
        end
        select = 1'b0;
        check("held pulse count", pulses, 32'd3);
        check("held claim 1", got[0], 32'h80000001);
        check("held claim 2", got[1], 32'h80000002);
        check("held claim 3", got[2], 32'h80000003);
        tick();
        tick();
        check("held cpu_irq after", {24'd0, cpu_irq}, 32'd0);

        // Reset during an access with an active source.
        do_reset();
        wr_reg(5'h00, 32'h01);
        src_irq = 8'h01;
        tick();
        tick();
        check("pre-reset cpu_irq", {24'd0, cpu_irq}, 32'h1);
        reset  = 1'b1;
        select = 1'b1;
        addr   = 5'h0C;
        wstrb  = 4'h0;
        tick();
        check("midrst ready",   {31'd0, ready},   32'd0);
        check("midrst data_o",  data_o,           32'd0);
        check("midrst cpu_irq", {24'd0, cpu_irq}, 32'd0);
        check("midrst irq_any", {31'd0, irq_any}, 32'd0);
        reset   = 1'b0;
        select  = 1'b0;
        src_irq = 8'h00;
        tick();
        check("postrst ready", {31'd0, ready}, 32'd0);
        rd_check("postrst enable",  5'h00, 32'd0);
        rd_check("postrst mode",    5'h08, 32'd0);
        rd_check("postrst pending", 5'h04, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
